// File: rtl/program_memory_loader_pkg.sv
// rtl/program_memory_loader_pkg.sv - shared state encoding and word geometry for the program loader
package program_memory_loader_pkg;

  // Loader FSM encoding, kept as plain constants for legacy tools
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RECV  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Word geometry: little-endian bytes packed into one instruction word
  localparam int BYTE_WIDTH     = 8;
  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_WIDTH     = $clog2(BYTES_PER_WORD);
  localparam int WORD_WIDTH     = BYTE_WIDTH * BYTES_PER_WORD;

endpackage

// File: rtl/loader_word_assembler.sv
// rtl/loader_word_assembler.sv - byte lane counter and little-endian word assembly register
module loader_word_assembler
  import program_memory_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  byte_fire,
  input  logic [BYTE_WIDTH-1:0] byte_data,
  output logic [WORD_WIDTH-1:0] word_data,
  output logic                  word_ready
);

  localparam logic [LANE_WIDTH-1:0] LAST_LANE = LANE_WIDTH'(BYTES_PER_WORD - 1);
  localparam logic [LANE_WIDTH-1:0] LANE_ONE  = LANE_WIDTH'(1);

  logic [LANE_WIDTH-1:0] lane;

  // Lane pointer advances on each accepted byte and wraps after the top lane
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane <= '0;
    end else if (clear) begin
      lane <= '0;
    end else if (byte_fire) begin
      lane <= lane + LANE_ONE;
    end
  end

  // Each accepted byte lands in its lane; older lanes keep their bytes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_data <= '0;
    end else if (byte_fire) begin
      word_data[BYTE_WIDTH*lane +: BYTE_WIDTH] <= byte_data;
    end
  end

  // The transfer that fills the top lane completes the word
  assign word_ready = byte_fire && (lane == LAST_LANE);

endmodule

// File: rtl/program_memory_loader.sv
// rtl/program_memory_loader.sv - byte-stream to program RAM loader with core reset control
module program_memory_loader
  import program_memory_loader_pkg::*;
#(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int CNT_WIDTH    = $clog2(MEMORY_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Start_i,
  input  logic [CNT_WIDTH-1:0]  Word_Count_i,
  input  logic [7:0]            Byte_i,
  input  logic                  Byte_Valid_i,
  output logic                  Byte_Ready_o,
  output logic                  Mem_Write_o,
  output logic [DATA_WIDTH-1:0] Mem_Address_o,
  output logic [DATA_WIDTH-1:0] Mem_Data_o,
  output logic                  Busy_o,
  output logic                  Done_o,
  output logic                  Error_o,
  output logic                  Cpu_Reset_n_o
);

  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(MEMORY_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [1:0]            state;
  logic [1:0]            state_next;
  logic [CNT_WIDTH-1:0]  count_q;
  logic [CNT_WIDTH-1:0]  index_q;
  logic                  start_seen;
  logic                  start_ok;
  logic                  start_bad;
  logic                  last_word;
  logic                  byte_fire;
  logic                  word_ready;
  logic [WORD_WIDTH-1:0] word_data;
  logic [DATA_WIDTH-1:0] addr_now;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  error_q;
  logic                  cpu_rst_n_q;

  assign start_seen = Start_i && (state == ST_IDLE);
  assign start_ok   = start_seen && (Word_Count_i != '0) && (Word_Count_i <= DEPTH_C);
  assign start_bad  = start_seen && !start_ok;
  assign last_word  = (index_q == count_q - CNT_ONE);
  assign byte_fire  = Byte_Valid_i && Byte_Ready_o;
  assign addr_now   = {{(DATA_WIDTH-CNT_WIDTH-2){1'b0}}, index_q, 2'b00};

  loader_word_assembler u_assembler (
    .clk        (clk),
    .rst_n      (reset),
    .clear      (start_ok),
    .byte_fire  (byte_fire),
    .byte_data  (Byte_i),
    .word_data  (word_data),
    .word_ready (word_ready)
  );

  // Next-state selection for the load sequence
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (start_ok)   state_next = ST_RECV;
      ST_RECV:  if (word_ready) state_next = ST_WRITE;
      ST_WRITE: state_next = last_word ? ST_DONE : ST_RECV;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // State register; an async reset drops any load in progress
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Latched word count and write index for the current image
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      index_q <= '0;
    end else if (start_ok) begin
      count_q <= Word_Count_i;
      index_q <= '0;
    end else if ((state == ST_WRITE) && !last_word) begin
      index_q <= index_q + CNT_ONE;
    end
  end

  // Sticky error for bad counts and core reset hold/release around a load
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      error_q     <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else if (start_ok) begin
      error_q     <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else if (start_bad) begin
      error_q     <= 1'b1;
    end else if (state == ST_DONE) begin
      cpu_rst_n_q <= 1'b1;
    end
  end

  // Capture the bus values of each write so they hold until the next one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      data_q <= '0;
    end else if (state == ST_WRITE) begin
      addr_q <= addr_now;
      data_q <= DATA_WIDTH'(word_data);
    end
  end

  assign Byte_Ready_o  = (state == ST_RECV);
  assign Mem_Write_o   = (state == ST_WRITE);
  assign Mem_Address_o = (state == ST_WRITE) ? addr_now : addr_q;
  assign Mem_Data_o    = (state == ST_WRITE) ? DATA_WIDTH'(word_data) : data_q;
  assign Busy_o        = (state == ST_RECV) || (state == ST_WRITE);
  assign Done_o        = (state == ST_DONE);
  assign Error_o       = error_q;
  assign Cpu_Reset_n_o = cpu_rst_n_q;

endmodule

// File: tb/tb_program_memory_loader.sv
// tb/tb_program_memory_loader.sv - scoreboard bench for the program memory loader
module tb_program_memory_loader;

  localparam int DEPTH = 32;
  localparam int DW    = 32;
  localparam int CW    = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          Start_i = 1'b0;
  logic [CW-1:0] Word_Count_i = '0;
  logic [7:0]    Byte_i = '0;
  logic          Byte_Valid_i = 1'b0;
  logic          Byte_Ready_o;
  logic          Mem_Write_o;
  logic [DW-1:0] Mem_Address_o;
  logic [DW-1:0] Mem_Data_o;
  logic          Busy_o;
  logic          Done_o;
  logic          Error_o;
  logic          Cpu_Reset_n_o;

  int checks = 0;
  int errors = 0;
  int write_count = 0;
  int done_count = 0;
  logic [63:0] exp_q[$];
  logic [31:0] img[DEPTH];

  program_memory_loader #(.MEMORY_DEPTH(DEPTH), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .Start_i       (Start_i),
    .Word_Count_i  (Word_Count_i),
    .Byte_i        (Byte_i),
    .Byte_Valid_i  (Byte_Valid_i),
    .Byte_Ready_o  (Byte_Ready_o),
    .Mem_Write_o   (Mem_Write_o),
    .Mem_Address_o (Mem_Address_o),
    .Mem_Data_o    (Mem_Data_o),
    .Busy_o        (Busy_o),
    .Done_o        (Done_o),
    .Error_o       (Error_o),
    .Cpu_Reset_n_o (Cpu_Reset_n_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every RAM write is popped against the scoreboard
  always @(negedge clk) begin
    logic [63:0] e;
    if (reset && Mem_Write_o) begin
      write_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", Mem_Address_o, Mem_Data_o);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", Mem_Address_o, e[63:32]);
        check("write_data", Mem_Data_o, e[31:0]);
        check("ready_in_write", {31'd0, Byte_Ready_o}, 32'd0);
      end
    end
    if (reset && Done_o) done_count++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic start(input int cnt);
    @(posedge clk); #1;
    Start_i = 1'b1;
    Word_Count_i = CW'(cnt);
    @(posedge clk); #1;
    Start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    logic rdy;
    if (gap) begin
      Byte_Valid_i = 1'b0;
      @(posedge clk); #1;
    end
    Byte_i = b;
    Byte_Valid_i = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      rdy = Byte_Ready_o;
      @(posedge clk); #1;
      if (rdy) break;
      n++;
      if (n > 20) begin
        checks++;
        errors++;
        $display("FAIL byte_accept: got no ready expected ready within 20 cycles");
        break;
      end
    end
    Byte_Valid_i = 1'b0;
  endtask

  task automatic finish_load();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!Done_o && n < 10);
    check("done_latency", n, 2);
    @(negedge clk);
    check("cpu_release", {31'd0, Cpu_Reset_n_o}, 32'd1);
    check("done_pulse_width", {31'd0, Done_o}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic load(input int cnt, input bit gap);
    for (int i = 0; i < cnt; i++) exp_q.push_back({32'(i * 4), img[i]});
    start(cnt);
    check("busy_after_start", {31'd0, Busy_o}, 32'd1);
    check("cpu_held", {31'd0, Cpu_Reset_n_o}, 32'd0);
    check("error_cleared", {31'd0, Error_o}, 32'd0);
    for (int i = 0; i < cnt; i++)
      for (int b = 0; b < 4; b++) send_byte(img[i][8*b +: 8], gap);
    finish_load();
  endtask

  initial begin
    int w0;
    int d0;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_n", {31'd0, Cpu_Reset_n_o}, 32'd0);
    check("rst_addr", Mem_Address_o, 32'd0);
    check("rst_data", Mem_Data_o, 32'd0);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_cpu_n", {31'd0, Cpu_Reset_n_o}, 32'd0);
    check("idle_write", {31'd0, Mem_Write_o}, 32'd0);
    check("idle_ready", {31'd0, Byte_Ready_o}, 32'd0);
    check("idle_done", {31'd0, Done_o}, 32'd0);
    check("idle_busy", {31'd0, Busy_o}, 32'd0);
    check("idle_error", {31'd0, Error_o}, 32'd0);

    // Single word at full rate
    img[0] = 32'h0000_0013;
    load(1, 1'b0);

    // Three words with a gap before every byte
    img[0] = 32'h0050_0093;
    img[1] = 32'h0010_0113;
    img[2] = 32'h0020_81B3;
    load(3, 1'b1);

    // Full depth, value equals index
    for (int i = 0; i < DEPTH; i++) img[i] = 32'(i);
    w0 = write_count;
    d0 = done_count;
    load(DEPTH, 1'b0);
    check("full_write_pulses", 32'(write_count - w0), 32'd32);
    check("full_done_pulses", 32'(done_count - d0), 32'd1);
    check("addr_held", Mem_Address_o, 32'h7C);
    check("data_held", Mem_Data_o, 32'd31);

    // Illegal counts
    w0 = write_count;
    start(0);
    check("err_zero", {31'd0, Error_o}, 32'd1);
    check("err_zero_busy", {31'd0, Busy_o}, 32'd0);
    check("err_cpu_kept", {31'd0, Cpu_Reset_n_o}, 32'd1);
    start(33);
    check("err_over", {31'd0, Error_o}, 32'd1);
    check("err_over_ready", {31'd0, Byte_Ready_o}, 32'd0);
    repeat (3) @(negedge clk);
    check("err_no_write", 32'(write_count - w0), 32'd0);
    img[0] = 32'hDEAD_BEEF;
    load(1, 1'b0);
    check("err_after_legal", {31'd0, Error_o}, 32'd0);

    // Async reset in the middle of a two-word load
    img[0] = 32'h1122_3344;
    img[1] = 32'h5566_7788;
    exp_q.push_back({32'h0, img[0]});
    start(2);
    for (int b = 0; b < 4; b++) send_byte(img[0][8*b +: 8], 1'b0);
    send_byte(img[1][7:0], 1'b0);
    reset = 1'b0;
    #1;
    check("abort_write", {31'd0, Mem_Write_o}, 32'd0);
    check("abort_cpu_n", {31'd0, Cpu_Reset_n_o}, 32'd0);
    check("abort_busy", {31'd0, Busy_o}, 32'd0);
    check("abort_ready", {31'd0, Byte_Ready_o}, 32'd0);
    check("abort_addr", Mem_Address_o, 32'd0);
    check("abort_first_word_written", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    w0 = write_count;
    repeat (5) @(negedge clk);
    check("abort_no_more_writes", 32'(write_count - w0), 32'd0);
    img[0] = 32'hCAFE_F00D;
    load(1, 1'b0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_memory_loader.md
Name: program_memory_loader

Overview:
- Writer side of the instruction-memory interface: receives a byte stream from a host (UART receiver or debug bridge) and assembles it into 32-bit instructions.
- Writes each instruction, one word per cycle, into a writable program RAM using the same word-aligned byte addressing the fetch path uses (word index = Address[16:2]).
- Holds the core in reset for the whole load and releases it when the image is complete.

Parameters:
- MEMORY_DEPTH, 32, number of instruction words in the target RAM.
- DATA_WIDTH, 32, instruction and address width; must be 32 (4 bytes per word).
- CNT_WIDTH, $clog2(MEMORY_DEPTH)+1, width of the word-count and word-index registers.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Start_i  in  1  one-cycle pulse that begins a load; sampled only in IDLE.
- Word_Count_i  in  CNT_WIDTH  number of words to load; latched on an accepted Start_i.
- Byte_i  in  8  incoming byte, little-endian within each word.
- Byte_Valid_i  in  1  Byte_i is valid.
- Byte_Ready_o  out  1  loader accepts a byte this cycle.
- Mem_Write_o  out  1  write strobe to program RAM.
- Mem_Address_o  out  DATA_WIDTH  byte address, word-aligned (index<<2).
- Mem_Data_o  out  DATA_WIDTH  assembled instruction.
- Busy_o  out  1  high in RECV or WRITE.
- Done_o  out  1  one-cycle pulse when a load completes.
- Error_o  out  1  sticky flag: Start_i seen with an illegal Word_Count_i.
- Cpu_Reset_n_o  out  1  active-low reset to the core.

Behaviour:
- Reset (async, reset=0):
  - State = IDLE.
  - All outputs 0, including Cpu_Reset_n_o (core held until the first successful load).
  - Assembly register, byte lane, word index and latched count all 0.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - Byte_Ready_o=0.
  - Start_i with 1 <= Word_Count_i <= MEMORY_DEPTH: latch the count, clear word index and byte lane, set Cpu_Reset_n_o=0 and Error_o=0, go to RECV next cycle.
  - Start_i with Word_Count_i=0 or > MEMORY_DEPTH: set Error_o=1, stay in IDLE, leave Cpu_Reset_n_o unchanged.
- RECV:
  - Byte_Ready_o=1 combinationally in this state.
  - A transfer happens when Byte_Valid_i & Byte_Ready_o. The byte is written into bits [8*lane+7:8*lane] and lane increments.
  - The transfer on lane 3 moves to WRITE; lane wraps to 0.
  - Byte_Valid_i low: state holds, no change.
- WRITE (exactly one cycle):
  - Mem_Write_o=1, Mem_Address_o={index,2'b00} zero-extended, Mem_Data_o = assembled word.
  - Byte_Ready_o=0, so the source stalls for this one cycle.
  - If index == count-1, go to DONE; otherwise increment index and return to RECV.
- DONE (one cycle): Done_o=1, Cpu_Reset_n_o set to 1 (registered), go to IDLE.
- Outside WRITE: Mem_Write_o=0; Mem_Address_o and Mem_Data_o hold their last values.
- Timing:
  - Load latency for N words = 1 (start) + 4N byte cycles (at full rate) + N write cycles + 1 done cycle.
  - Sustained rate: 4 bytes per 5 cycles.
- Start_i while Busy_o or in DONE: ignored, no error.
- Cpu_Reset_n_o stays 1 after a load until the next accepted Start_i. Earlier RAM contents beyond the new count are not cleared.
- An asynchronous reset mid-load aborts the load immediately: no further writes, core held in reset, partially written words remain in RAM.
- Byte_i is don't-care when Byte_Valid_i=0.

Decomposition:
- Shared package: loader state encoding (IDLE=2'd0, RECV=2'd1, WRITE=2'd2, DONE=2'd3) and BYTES_PER_WORD=4.
- One natural sub-module, loader_word_assembler: byte lane counter plus shift/assembly register, with a word_ready output.
- FSM, index counter and reset control stay in the top module.

Test Plan:
- Reset then idle: after reset release, no stimulus for 10 cycles -> Cpu_Reset_n_o=0, Mem_Write_o=0, Byte_Ready_o=0, Done_o=0.
- Single-word load: Start_i with count=1, bytes 13,00,00,00 back-to-back -> one write at address 0x0 with data 0x00000013; Done_o 2 cycles after the 4th byte; Cpu_Reset_n_o=1 the following cycle.
- Three-word load with gaps: count=3, bytes with Byte_Valid_i toggled every other cycle -> writes at 0x0, 0x4, 0x8 carrying the correct little-endian words; Byte_Ready_o=0 in each WRITE cycle.
- Full depth: count=32, words 0..31 with value = index -> last write at address 0x7C; exactly 32 Mem_Write_o pulses; a single Done_o.
- Illegal counts: Start_i with count=0, then count=33 -> Error_o=1, state stays IDLE, no writes; a subsequent legal Start_i clears Error_o.
- Reset mid-load: count=2, assert reset after 5 bytes -> no write issued after the reset, outputs at reset values; a restarted load of 1 word writes address 0x0.
